// File: rtl/axi_master_wr_arbiter_pkg.sv
// Shared types and constants for the AXI master write-side arbiter and its
// reusable round-robin core.
package axi_master_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LAUNCH   = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_RESP     = 2'd3
  } wr_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  localparam logic [1:0] AWLOCK_DEF  = 2'b00;
  localparam logic [1:0] AWCACHE_DEF = 2'b00;
  localparam logic [2:0] AWPROT_DEF  = 3'b000;

  localparam int TXN_ID_W = 4;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_master_wr_arbiter_if.sv
// Requester-side and decoder-side write signals of the arbiter, grouped so the
// arbiter drives everything through the master modport.
interface axi_master_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    // Requester side
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*addr_width-1:0] req_awaddr;
    logic [NUM_REQ*8-1:0]          req_awlen;
    logic [NUM_REQ*3-1:0]          req_awsize;
    logic [NUM_REQ*2-1:0]          req_awburst;
    logic [NUM_REQ*data_width-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]          req_wstrb;
    logic [NUM_REQ-1:0]            req_wvalid;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [1:0]                    rsp_bresp;
    logic                          rsp_timeout;

    // Decoder side
    logic [3:0]                    TXN_ID_W_d;
    logic [addr_width-1:0]         awaddr_d;
    logic [7:0]                    awlen_d;
    logic [2:0]                    awsize_d;
    logic [1:0]                    awburst_d;
    logic [1:0]                    awlock_d;
    logic [1:0]                    awcache_d;
    logic [2:0]                    awprot_d;
    logic [data_width-1:0]         wdata_d;
    logic [3:0]                    wstrb_d;
    logic                          wvalid_d;
    logic                          wr_trn_en;
    logic [1:0]                    bresp_d;
    logic [3:0]                    bid_d;
    logic                          wr_rsp_en_d;
    logic                          id_mismatch;

    modport master (
        input  req, req_awaddr, req_awlen, req_awsize, req_awburst,
               req_wdata, req_wstrb, req_wvalid,
        output gnt, rsp_valid, rsp_bresp, rsp_timeout,
        output TXN_ID_W_d, awaddr_d, awlen_d, awsize_d, awburst_d,
               awlock_d, awcache_d, awprot_d, wdata_d, wstrb_d, wvalid_d,
               wr_trn_en, id_mismatch,
        input  bresp_d, bid_d, wr_rsp_en_d
    );

    modport slave (
        output req, req_awaddr, req_awlen, req_awsize, req_awburst,
               req_wdata, req_wstrb, req_wvalid,
        input  gnt, rsp_valid, rsp_bresp, rsp_timeout,
        input  TXN_ID_W_d, awaddr_d, awlen_d, awsize_d, awburst_d,
               awlock_d, awcache_d, awprot_d, wdata_d, wstrb_d, wvalid_d,
               wr_trn_en, id_mismatch,
        output bresp_d, bid_d, wr_rsp_en_d
    );

endinterface

// File: rtl/axi_master_wr_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping; returns one-hot grant and its index.
module axi_master_wr_arbiter_rr #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin : pick
        int          ci;
        logic [IW-1:0] c;
        ci    = 0;
        c     = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            ci = int'(ptr_i) + k;
            if (ci >= N) ci = ci - N;
            c = IW'(ci);
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end

endmodule

// File: rtl/axi_master_wr_arbiter.sv
// Round-robin write-side arbiter: grants one requester, launches its write on
// the decoder interface and holds the grant until the response or a timeout.
module axi_master_wr_arbiter
    import axi_master_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int addr_width  = 32,
    parameter int data_width  = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                   AClk,
    input logic                   ARst,
    axi_master_wr_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    wr_state_e          state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         code_q, code_d;
    logic               tmo_q, tmo_d;
    logic               idmis_q, idmis_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               busy;
    logic [3:0]         txn_id;

    // Packed per-requester views of the flattened request buses
    logic [NUM_REQ-1:0][addr_width-1:0] awaddr_a;
    logic [NUM_REQ-1:0][7:0]            awlen_a;
    logic [NUM_REQ-1:0][2:0]            awsize_a;
    logic [NUM_REQ-1:0][1:0]            awburst_a;
    logic [NUM_REQ-1:0][data_width-1:0] wdata_a;
    logic [NUM_REQ-1:0][3:0]            wstrb_a;

    assign awaddr_a  = bus.req_awaddr;
    assign awlen_a   = bus.req_awlen;
    assign awsize_a  = bus.req_awsize;
    assign awburst_a = bus.req_awburst;
    assign wdata_a   = bus.req_wdata;
    assign wstrb_a   = bus.req_wstrb;

    axi_master_wr_arbiter_rr #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_ff @(posedge AClk) begin
        if (ARst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            tmo_q   <= 1'b0;
            idmis_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            tmo_q   <= tmo_d;
            idmis_q <= idmis_d;
        end
    end

    assign txn_id = 4'(idx_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        tmo_d   = tmo_q;
        idmis_d = idmis_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                // A real response beats a timeout landing in the same cycle
                if (bus.wr_rsp_en_d) begin
                    code_d  = bus.bresp_d;
                    tmo_d   = 1'b0;
                    if (bus.bid_d != txn_id) idmis_d = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = BRESP_SLVERR;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                ptr_d   = IW'(rr_next(int'(idx_q), NUM_REQ));
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_LAUNCH) || (state_q == S_WAIT_RSP);

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = (state_q == S_RESP) ? gnt_q : '0;
    assign bus.rsp_bresp   = (state_q == S_RESP) ? code_q : BRESP_OKAY;
    assign bus.rsp_timeout = (state_q == S_RESP) && tmo_q;
    assign bus.wr_trn_en   = (state_q == S_LAUNCH);
    assign bus.id_mismatch = idmis_q;
    assign bus.TXN_ID_W_d  = txn_id;

    assign bus.awaddr_d  = busy ? awaddr_a[idx_q]  : '0;
    assign bus.awlen_d   = busy ? awlen_a[idx_q]   : '0;
    assign bus.awsize_d  = busy ? awsize_a[idx_q]  : '0;
    assign bus.awburst_d = busy ? awburst_a[idx_q] : '0;
    assign bus.wdata_d   = busy ? wdata_a[idx_q]   : '0;
    assign bus.wstrb_d   = busy ? wstrb_a[idx_q]   : '0;
    assign bus.wvalid_d  = busy && bus.req_wvalid[idx_q];
    assign bus.awlock_d  = AWLOCK_DEF;
    assign bus.awcache_d = AWCACHE_DEF;
    assign bus.awprot_d  = AWPROT_DEF;

endmodule
